// File: rtl/decode_stage.sv
// Instruction decode stage: 32x32 register file with write-through bypass,
// opcode control decode, load-use stall detection and the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] Next_PC,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] PC_out,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_ext,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        branch,
    output logic [1:0]  alu_op
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic [1:0]  alu_op;
    } id_ex_t;

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    id_ex_t      id_ex_q, id_ex_d;

    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic        wr_live;
    logic        legal, uses_rt, stall_c;

    assign opcode  = instruction[31:26];
    assign rs      = instruction[25:21];
    assign rt      = instruction[20:16];
    assign rd      = instruction[15:11];
    assign wr_live = wb_en && (wb_addr != 5'd0);

    always_comb begin
        rf_d = rf_q;
        if (wr_live) rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    // Reads see a same-cycle writeback so WB->ID needs no extra forwarding.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0) rs_val = (wr_live && wb_addr == rs) ? wb_data : rf_q[rs];
        if (rt != 5'd0) rt_val = (wr_live && wb_addr == rt) ? wb_data : rf_q[rt];
    end

    always_comb begin
        id_ex_d = '0;
        legal   = 1'b1;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.reg_dst   = 1'b1;
                id_ex_d.alu_op    = 2'b10;
                uses_rt           = 1'b1;
            end
            OP_LW: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.mem_read   = 1'b1;
                id_ex_d.mem_to_reg = 1'b1;
                id_ex_d.alu_src    = 1'b1;
            end
            OP_SW: begin
                id_ex_d.mem_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                uses_rt           = 1'b1;
            end
            OP_BEQ: begin
                id_ex_d.branch = 1'b1;
                id_ex_d.alu_op = 2'b01;
                uses_rt        = 1'b1;
            end
            OP_ADDI: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // rt only counts as a source for opcodes that actually read it.
        stall_c = !reset && !flush && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (uses_rt && ex_rt == rt));

        id_ex_d.valid   = 1'b1;
        id_ex_d.pc      = Next_PC;
        id_ex_d.rs_data = rs_val;
        id_ex_d.rt_data = rt_val;
        id_ex_d.imm     = {{16{instruction[15]}}, instruction[15:0]};
        id_ex_d.rs      = rs;
        id_ex_d.rt      = rt;
        id_ex_d.rd      = rd;
        if (flush || stall_c || !legal) id_ex_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) id_ex_q <= '0;
        else       id_ex_q <= id_ex_d;
    end

    assign stall      = stall_c;
    assign valid_out  = id_ex_q.valid;
    assign PC_out     = id_ex_q.pc;
    assign rs_data    = id_ex_q.rs_data;
    assign rt_data    = id_ex_q.rt_data;
    assign imm_ext    = id_ex_q.imm;
    assign rs_out     = id_ex_q.rs;
    assign rt_out     = id_ex_q.rt;
    assign rd_out     = id_ex_q.rd;
    assign reg_write  = id_ex_q.reg_write;
    assign mem_read   = id_ex_q.mem_read;
    assign mem_write  = id_ex_q.mem_write;
    assign mem_to_reg = id_ex_q.mem_to_reg;
    assign alu_src    = id_ex_q.alu_src;
    assign reg_dst    = id_ex_q.reg_dst;
    assign branch     = id_ex_q.branch;
    assign alu_op     = id_ex_q.alu_op;

endmodule
